serial_word_subtractor: RTL and testbench
=========================================

# serial_word_subtractor

Parallel-in, bit-serial subtractor companion to the serial adder FSM. Each accepted operation loads two WIDTH-bit words and walks them LSB-first through a two-state borrow FSM, one bit per clock. The difference bits are collected back into a parallel word. It gives the datapath the inverse operation of the serial adder, with a start/done handshake so a controller can drive it word by word.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  request: compute a_in − b_in; sampled only when idle/done
- a_in  input  WIDTH  minuend, captured on the accepting edge
- b_in  input  WIDTH  subtrahend, captured on the accepting edge
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; diff/borrow valid from this cycle
- diff  output  WIDTH  a_in − b_in mod 2^WIDTH, held until next completion
- borrow  output  1  final borrow out (1 = a_in < b_in unsigned), held with diff
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN

## Operation
- States: IDLE, RUN_NB (running, borrow = 0), RUN_B (running, borrow = 1), FIN.
- IDLE/FIN + start=1: load a_sr←a_in, b_sr←b_in, bit counter←0, go to RUN_NB. Borrow-in is always 0.
- IDLE/FIN + start=0: IDLE→IDLE, FIN→IDLE.
- RUN_x, each edge, with a0=a_sr[0], b0=b_sr[0], br = (state==RUN_B):
  - d = a0^b0^br
  - br_next = (~a0&b0) | (~(a0^b0)&br)
  - shift a_sr and b_sr right by one
  - shift d into res_sr at the MSB (right shift)
  - increment the counter
  - next state is RUN_B if br_next else RUN_NB
- Last bit (counter == WIDTH−1):
  - next state = FIN
  - diff ← {d, res_sr[WIDTH−1:1]}
  - borrow ← br_next
- busy = 1 in RUN_NB/RUN_B. done = 1 in FIN only.
- start is ignored while busy. a_in/b_in are don't-care outside the accepting edge.
- diff/borrow (and ovf) change only on the last-bit edge. During a run they hold the previous result.
- Reset (any time, including mid-run) forces:
  - state = IDLE
  - busy = 0, done = 0, diff = 0, borrow = 0, ovf = 0
  - counter and shift registers = 0
  - The partial operation is discarded.
  - Operation resumes on the first edge after reset deasserts.

## Timing
- Accept edge E0. Bits are processed on E1..E_WIDTH. FIN (done=1, busy=0) is the cycle after E_WIDTH.
- Latency from accepting edge to done: WIDTH+1 edges. Throughput: one op per WIDTH+1 cycles with back-to-back start asserted in FIN.
- busy rises the cycle after E0 and falls in the same cycle done rises.
- done is never asserted for two consecutive cycles.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - Port ovf exists.
  - ovf ← (a_msb≠b_msb) & (d_msb≠a_msb) at the last-bit edge, where a_msb/b_msb are the captured operand MSBs (the final a0/b0).
  - ovf is held with diff and reset to 0.
- Not defined: port ovf and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold reset=0 for 2 cycles, then release → busy=0, done=0, diff=8'h00, borrow=0. Remain IDLE with start=0.
- 200 − 55 (WIDTH=8) → done exactly 9 edges after the accept edge, diff=8'h91, borrow=0. busy high for 8 cycles.
- 5 − 9 → diff=8'hFC, borrow=1. 9 − 9 → diff=8'h00, borrow=0.
- Hold start=1 with new operands during run → ignored, result matches the first operands. Assert start in the FIN cycle with 8'hFF − 8'h01 → next run starts without an IDLE cycle, diff=8'hFE.
- Assert reset at the 4th bit of 8'hA5 − 8'h3C → outputs all 0 immediately (asynchronous). A fresh start after release gives diff=8'h69, borrow=0.
- With SERIAL_SUB_OVF_EN: 8'h80 − 8'h01 → diff=8'h7F, borrow=0, ovf=1. 8'h10 − 8'h20 → diff=8'hF0, borrow=1, ovf=0.

Source files
------------

// File: rtl/serial_word_subtractor.sv
// Bit-serial subtractor: loads two words, walks them LSB-first through a borrow FSM, returns a parallel difference.
// Optional signed-overflow output ovf is built when SERIAL_SUB_OVF_EN is defined.
module serial_word_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_NB = 2'd1,
        RUN_B  = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    logic a0, b0, br, d, br_next, last_bit;

    always_comb begin
        a0       = a_sr_q[0];
        b0       = b_sr_q[0];
        br       = (state_q == RUN_B);
        d        = a0 ^ b0 ^ br;
        br_next  = (~a0 & b0) | (~(a0 ^ b0) & br);
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE, FIN: begin
                if (start) begin
                    a_sr_d  = a_in;
                    b_sr_d  = b_in;
                    cnt_d   = '0;
                    state_d = RUN_NB;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN_NB, RUN_B: begin
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                res_sr_d = {d, res_sr_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CW'(1);
                state_d  = br_next ? RUN_B : RUN_NB;
                if (last_bit) begin
                    // On the last bit a0/b0/d are the operand and result sign bits.
                    state_d  = FIN;
                    diff_d   = {d, res_sr_q[WIDTH-1:1]};
                    borrow_d = br_next;
                    ovf_d    = (a0 ^ b0) & (d ^ a0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q == RUN_NB) || (state_q == RUN_B);
    assign done   = (state_q == FIN);
    assign diff   = diff_q;
    assign borrow = borrow_q;

`ifdef SERIAL_SUB_OVF_EN
    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_word_subtractor.sv
// Directed-vector bench for serial_word_subtractor (WIDTH=8); ovf vectors built with SERIAL_SUB_OVF_EN.
module tb_serial_word_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             busy, done, borrow;
    logic [WIDTH-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    serial_word_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .borrow(borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for done; returns edges counted from the accept edge and busy cycles seen.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges = 1;
        busy_cycles = 0;
        while (done !== 1'b1 && edges < 40) begin
            if (busy === 1'b1) busy_cycles++;
            @(posedge clk); #1;
            edges++;
        end
        chk("done_timeout", 32'(edges < 40), 32'd1);
    endtask

    // Accepts one operation; returns just after the accept edge with start released.
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk); #1;
        start = 1'b0;
        a_in  = 8'h00;
        b_in  = 8'h00;
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp_d, input logic exp_b);
        int e, bc;
        launch(a, b);
        wait_done(e, bc);
        chk({tag, "_diff"}, 32'(diff), 32'(exp_d));
        chk({tag, "_borrow"}, 32'(borrow), 32'(exp_b));
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_diff_hold"}, 32'(diff), 32'(exp_d));
    endtask

    initial begin
        int e, bc;

        // Reset held for two cycles
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'h00);
        chk("rst_borrow", 32'(borrow), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        // 200 - 55 with latency and busy-width checks
        launch(8'd200, 8'd55);
        chk("acc_busy", 32'(busy), 32'd1);
        wait_done(e, bc);
        chk("lat_edges", 32'(e), 32'd9);
        chk("busy_cycles", 32'(bc), 32'd8);
        chk("fin_busy", 32'(busy), 32'd0);
        chk("200m55_diff", 32'(diff), 32'h91);
        chk("200m55_borrow", 32'(borrow), 32'd0);
        @(posedge clk); #1;
        chk("200m55_done_pulse", 32'(done), 32'd0);

        run_op("5m9", 8'd5, 8'd9, 8'hFC, 1'b1);

        // 9 - 9 with start held and fresh operands during the run, then back-to-back FF - 01
        @(negedge clk);
        start = 1'b1;
        a_in  = 8'd9;
        b_in  = 8'd9;
        @(posedge clk); #1;
        a_in  = 8'hFF;
        b_in  = 8'h01;
        wait_done(e, bc);
        chk("9m9_lat", 32'(e), 32'd9);
        chk("9m9_diff", 32'(diff), 32'h00);
        chk("9m9_borrow", 32'(borrow), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_done", 32'(done), 32'd0);
        chk("b2b_diff_held", 32'(diff), 32'h00);
        wait_done(e, bc);
        chk("ffm01_lat", 32'(e), 32'd9);
        chk("ffm01_diff", 32'(diff), 32'hFE);
        chk("ffm01_borrow", 32'(borrow), 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of A5 - 3C
        launch(8'hA5, 8'h3C);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_diff", 32'(diff), 32'h00);
        chk("mid_rst_borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_rst_busy", 32'(busy), 32'd0);
        run_op("a5m3c", 8'hA5, 8'h3C, 8'h69, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
        run_op("80m01", 8'h80, 8'h01, 8'h7F, 1'b0);
        chk("80m01_ovf", 32'(ovf), 32'd1);
        run_op("10m20", 8'h10, 8'h20, 8'hF0, 1'b1);
        chk("10m20_ovf", 32'(ovf), 32'd0);
`else
        run_op("80m01", 8'h80, 8'h01, 8'h7F, 1'b0);
        run_op("10m20", 8'h10, 8'h20, 8'hF0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
